// File: rtl/edge_gen.sv
// rtl/edge_gen.sv - edge generator with minimum per-level hold time (optional EDGE_GEN_QUEUE_EN pending buffer)
module edge_gen #(
    parameter int   HOLD_CYC = 4,
    parameter logic INIT_LVL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [1:0] sel,
    output logic       ready,
    output logic       done,
    output logic       dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Counter reload: a level loaded at edge N is held through edge N+HOLD_CYC.
    localparam logic [7:0] RELOAD = 8'(HOLD_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dout_q, dout_d;
    logic       tgt_q, tgt_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;

    logic       accept;
    logic       start;
    logic [1:0] start_sel;
    logic       target;

`ifdef EDGE_GEN_QUEUE_EN
    logic       buf_v_q, buf_v_d;
    logic [1:0] buf_sel_q, buf_sel_d;
`endif

    // Next-state, counter, level and handshake decisions.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        tgt_d     = tgt_q;
        done_d    = 1'b0;
        start     = 1'b0;
        start_sel = sel;
        target    = 1'b0;
        accept    = req & ready_q;
`ifdef EDGE_GEN_QUEUE_EN
        buf_v_d   = buf_v_q;
        buf_sel_d = buf_sel_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    start = 1'b1;
                end
            end
            PREP: begin
                if (cnt_q == 8'd0) begin
                    dout_d  = tgt_q;
                    cnt_d   = RELOAD;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
`ifdef EDGE_GEN_QUEUE_EN
                if (accept) begin
                    buf_v_d   = 1'b1;
                    buf_sel_d = sel;
                end
`endif
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef EDGE_GEN_QUEUE_EN
                    // A buffered request starts at the exit edge with no idle gap;
                    // a request accepted on this same edge (buffer empty) starts directly.
                    if (buf_v_q) begin
                        start     = 1'b1;
                        start_sel = buf_sel_q;
                        buf_v_d   = 1'b0;
                    end else if (accept) begin
                        start = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
`ifdef EDGE_GEN_QUEUE_EN
                    if (accept) begin
                        buf_v_d   = 1'b1;
                        buf_sel_d = sel;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new edge: if the line already sits at the target, first drive the
        // opposite level for a full hold so an actual edge is produced.
        if (start) begin
            target = start_sel[1] ? ~dout_q : ~start_sel[0];
            tgt_d  = target;
            cnt_d  = RELOAD;
            if (dout_q == target) begin
                dout_d  = ~target;
                state_d = PREP;
            end else begin
                dout_d  = target;
                state_d = HOLD;
            end
        end

`ifdef EDGE_GEN_QUEUE_EN
        ready_d = (state_d == IDLE) || !buf_v_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            dout_q  <= INIT_LVL;
            tgt_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            tgt_q   <= tgt_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef EDGE_GEN_QUEUE_EN
    // Pending request buffer, dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v_q   <= 1'b0;
            buf_sel_q <= 2'b00;
        end else begin
            buf_v_q   <= buf_v_d;
            buf_sel_q <= buf_sel_d;
        end
    end
`endif

    assign ready = ready_q;
    assign done  = done_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_edge_gen.sv
// tb/tb_edge_gen.sv - directed scoreboard bench for edge_gen (HOLD_CYC=4, INIT_LVL=0)
module tb_edge_gen;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [1:0] sel;
    logic       ready;
    logic       done;
    logic       dout;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic d;
        logic dn;
        logic r;
    } exp_t;

    exp_t sb[$];

`ifdef EDGE_GEN_QUEUE_EN
    localparam logic BR = 1'b1;
`else
    localparam logic BR = 1'b0;
`endif

    edge_gen #(
        .HOLD_CYC(4),
        .INIT_LVL(1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .sel  (sel),
        .ready(ready),
        .done (done),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle; expectation is queued with the stimulus and popped after the edge.
    task automatic tick(input string tag, input logic r_in, input logic [1:0] s_in,
                        input logic d, input logic dn, input logic r);
        exp_t e;
        sb.push_back('{d: d, dn: dn, r: r});
        req = r_in;
        sel = s_in;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".dout"},  dout,  e.d);
        chk({tag, ".done"},  done,  e.dn);
        chk({tag, ".ready"}, ready, e.r);
    endtask

    initial begin
        req   = 1'b0;
        sel   = 2'b00;
        rst_n = 1'b0;
        #12;
        chk("rst.dout",  dout,  1'b0);
        chk("rst.ready", ready, 1'b1);
        chk("rst.done",  done,  1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Rising edge from low: 4-cycle hold, done at acceptance+4.
        tick("rise.acc", 1'b1, 2'b00, 1'b1, 1'b0, BR);
        for (int i = 0; i < 3; i++) tick("rise.hold", 1'b0, 2'b00, 1'b1, 1'b0, BR);
        tick("rise.done", 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick("rise.idle", 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

        // Rising edge requested while already high: prep low, then high, done at +8.
        tick("prep.acc", 1'b1, 2'b00, 1'b0, 1'b0, BR);
        for (int i = 0; i < 3; i++) tick("prep.low", 1'b0, 2'b11, 1'b0, 1'b0, BR);
        for (int i = 0; i < 4; i++) tick("prep.high", 1'b0, 2'b01, 1'b1, 1'b0, BR);
        tick("prep.done", 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick("prep.idle", 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

`ifndef EDGE_GEN_QUEUE_EN
        // Three toggles with req held: each level lasts 5 cycles.
        for (int k = 0; k < 3; k++) begin
            logic lvl;
            lvl = (k == 1);
            tick("tog.acc", 1'b1, 2'b10, lvl, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) tick("tog.hold", 1'b1, 2'b10, lvl, 1'b0, 1'b0);
            tick("tog.done", 1'b1, 2'b10, lvl, 1'b1, 1'b1);
        end
        tick("tog.end", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        tick("tog.end2", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
`else
        // Plain toggle to bring the line low before the queue sequence.
        tick("tog.acc", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("tog.hold", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        tick("tog.done", 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        tick("tog.end", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
`endif

        // Falling request from low (prep path) aborted by reset at acceptance+2.
        tick("abort.acc", 1'b1, 2'b01, 1'b1, 1'b0, BR);
        tick("abort.h1", 1'b0, 2'b00, 1'b1, 1'b0, BR);
        tick("abort.h2", 1'b0, 2'b00, 1'b1, 1'b0, BR);
        rst_n = 1'b0;
        #1;
        chk("abort.dout",  dout,  1'b0);
        chk("abort.ready", ready, 1'b1);
        chk("abort.done",  done,  1'b0);
        for (int i = 0; i < 2; i++) tick("abort.inrst", 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        tick("post.acc", 1'b1, 2'b00, 1'b1, 1'b0, BR);
        for (int i = 0; i < 3; i++) tick("post.hold", 1'b0, 2'b00, 1'b1, 1'b0, BR);
        tick("post.done", 1'b0, 2'b00, 1'b1, 1'b1, 1'b1);
        tick("post.idle", 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);

`ifndef EDGE_GEN_QUEUE_EN
        // Requests while busy are ignored: one edge, one done.
        tick("busy.acc", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        tick("busy.ign1", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick("busy.ign2", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick("busy.hold", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick("busy.done", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick("busy.after", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
`else
        // Line is high; toggle low first, then queue a falling request behind a rise.
        tick("q.pre", 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick("q.prehold", 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        tick("q.predone", 1'b0, 2'b10, 1'b0, 1'b1, 1'b1);
        tick("q.acc1", 1'b1, 2'b00, 1'b1, 1'b0, 1'b1);
        tick("q.h1", 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
        tick("q.acc2", 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        tick("q.full", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        tick("q.done1", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick("q.h2", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick("q.done2", 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) tick("q.after", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
`endif

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb.drain: observed=%0d expected=0", sb.size());
        end
        checks++;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/edge_gen.md
EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 4, meaning the minimum number of cycles dout holds each level it drives; legal range 2..255.
REQ-002 SHALL have parameter INIT_LVL, default 1'b0, meaning the dout level after reset.
REQ-003 SHALL have one clock and an asynchronous active-low reset; clk, rst_n and the ports below are:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  edge request, sampled at clk rising edge.
- sel  input  2  edge type: 00 rising, 01 falling, 10/11 toggle; sampled only on acceptance.
- ready  output  1  high when a request can be accepted.
- dout  output  1  generated line, registered.
- done  output  1  one-cycle pulse when the requested edge has completed its hold time.

Function
REQ-004 SHALL accept a request at a clk edge where req=1 and ready=1; all other req cycles are ignored.
REQ-005 SHALL implement states IDLE, PREP and HOLD, with a counter of at least 8 bits.
REQ-006 SHALL, in IDLE on acceptance, compute the target level: sel=00 gives 1, sel=01 gives 0, sel=1x gives ~dout.
REQ-007 SHALL, on acceptance when dout already equals the target (possible only for sel=00/01):
- drive ~target at that edge;
- load the counter with HOLD_CYC-1;
- enter PREP.
REQ-008 SHALL, on acceptance otherwise, drive the target at the acceptance edge, load the counter with HOLD_CYC-1 and enter HOLD; dout changes in the cycle after acceptance.
REQ-009 SHALL, in PREP with counter=0, drive the target, reload HOLD_CYC-1 and enter HOLD; otherwise decrement.
REQ-010 SHALL, in HOLD with counter=0, enter IDLE, assert done for exactly one cycle and set ready=1; otherwise decrement.
REQ-011 SHALL keep every level driven by dout stable for exactly HOLD_CYC cycles in PREP and at least HOLD_CYC cycles in HOLD.
REQ-012 SHALL hold ready low in PREP and HOLD; ready, dout and done are register outputs.
REQ-013 SHALL give acceptance-to-done latency of HOLD_CYC cycles without prep and 2*HOLD_CYC cycles with prep.
REQ-014 SHALL ignore changes on sel after acceptance.
REQ-015 SHALL, when req=1 in the same cycle that done pulses, accept the request at the next edge; the idle cycle is guaranteed.

Reset
REQ-016 SHALL, while rst_n=0, asynchronously force state=IDLE, counter=0, dout=INIT_LVL, ready=1, done=0, and clear any pending request.
REQ-017 SHALL abort any operation in progress on reset assertion, with no done pulse.
REQ-018 SHALL, on rst_n deassertion, accept the first request at the next clk edge with req=1.

Configuration
REQ-019 SHALL provide macro EDGE_GEN_QUEUE_EN.
REQ-020 SHALL, with EDGE_GEN_QUEUE_EN defined, include a 1-entry pending buffer (valid + sel):
- ready = (state==IDLE) or (buffer empty).
- A request accepted while busy is stored in the buffer.
- At the HOLD-exit edge with the buffer valid, done pulses and the pending request starts at that same edge per REQ-006..REQ-008, with no IDLE cycle; the buffer is then cleared.
REQ-021 SHALL, with EDGE_GEN_QUEUE_EN defined, not accept req while busy with the buffer full (ready=0); nothing is overwritten.
REQ-022 SHALL, without EDGE_GEN_QUEUE_EN, behave per REQ-004..REQ-015 with no buffer logic synthesized.

Verification
REQ-023 SHALL cover: HOLD_CYC=4, reset, req=1 sel=00 for 1 cycle -> dout 0->1 the cycle after acceptance, high for 4 cycles, done pulses at acceptance+4, ready low 4 cycles.
REQ-024 SHALL cover: dout=1, req sel=00 -> dout=0 for 4 cycles, then 1 for 4 cycles, done at acceptance+8.
REQ-025 SHALL cover: three back-to-back sel=10 requests held continuously -> dout toggles 0,1,0, each level 5 cycles (4 hold + 1 idle), 3 done pulses.
REQ-026 SHALL cover: rst_n low at acceptance+2 of a sel=01 request -> dout=INIT_LVL immediately, ready=1, no done; a new request after reset works.
REQ-027 SHALL cover: req with sel=00 while busy (queue off) -> ignored, no extra edge, single done.
REQ-028 SHALL cover: queue on, second req sel=01 during HOLD -> accepted, dout falls at the first done edge, second done 4 cycles later; a third req while the buffer is full is not accepted.
